// File: rtl/seq_pkg.sv
// Shared definitions for the 4-bit sequence frame.
// Used by both the checker and the generator.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP1   = 3'd1,
        DN1   = 3'd2,
        UP2   = 3'd3,
        DN2   = 3'd4,
        FLUSH = 3'd5
    } state_t;

    localparam logic [3:0] UP1_MAX = 4'd12;
    localparam logic [3:0] DN1_MIN = 4'd0;
    localparam logic [3:0] UP2_MAX = 4'd9;
    localparam logic [3:0] DN2_MIN = 4'd3;

    localparam int         FRAME_LEN = 40;
    localparam logic [5:0] LAST_POS  = 6'd39;

endpackage

// File: rtl/seq_exp_next.sv
// Next expected symbol and phase from the current phase and symbol.
// Pure combinational; shared with the generator.
module seq_exp_next
    import seq_pkg::*;
(
    input  logic [2:0] i_state,
    input  logic [3:0] i_exp,
    output logic [2:0] o_state,
    output logic [3:0] o_exp,
    output logic       o_last
);

    state_t     w_state;
    logic [3:0] w_exp;
    logic       w_last;

    always_comb begin
        w_state = state_t'(i_state);
        w_exp   = i_exp;
        w_last  = 1'b0;
        case (state_t'(i_state))
            IDLE, UP1: begin
                if (i_exp == UP1_MAX) begin
                    w_state = DN1;
                    w_exp   = UP1_MAX - 4'd1;
                end else begin
                    w_state = UP1;
                    w_exp   = i_exp + 4'd1;
                end
            end
            DN1: begin
                if (i_exp == DN1_MIN) begin
                    w_state = UP2;
                    w_exp   = DN1_MIN + 4'd1;
                end else begin
                    w_exp = i_exp - 4'd1;
                end
            end
            UP2: begin
                if (i_exp == UP2_MAX) begin
                    w_state = DN2;
                    w_exp   = UP2_MAX - 4'd1;
                end else begin
                    w_exp = i_exp + 4'd1;
                end
            end
            DN2: begin
                if (i_exp == DN2_MIN) begin
                    w_state = IDLE;
                    w_exp   = 4'd0;
                    w_last  = 1'b1;
                end else begin
                    w_exp = i_exp - 4'd1;
                end
            end
            default: begin
                w_state = state_t'(i_state);
                w_exp   = i_exp;
            end
        endcase
    end

    assign o_state = w_state;
    assign o_exp   = w_exp;
    assign o_last  = w_last;

endmodule

// File: rtl/seq_chk.sv
// Receive-side checker for the 40-sample sequence frame.
// Reports good/bad frames and keeps saturating frame counters.
module seq_chk
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    input  logic             cnt_clr,
    output logic             busy,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [5:0]       err_pos,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           r_state;
    logic [3:0]       r_exp;
    logic [5:0]       r_pos;
    logic             r_ok;
    logic             r_err;
    logic [5:0]       r_err_pos;
    logic [CNT_W-1:0] r_fcnt;
    logic [CNT_W-1:0] r_ecnt;

    logic [2:0]       w_nstate;
    logic [3:0]       w_nexp;
    logic             w_done;
    logic             w_match;

    seq_exp_next u_next (
        .i_state (r_state),
        .i_exp   (r_exp),
        .o_state (w_nstate),
        .o_exp   (w_nexp),
        .o_last  (w_done)
    );

    // in_last is part of the symbol: it must appear exactly at the last position
    assign w_match = (in_data == r_exp) &&
                     (in_last == (r_pos == LAST_POS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_exp     <= 4'd0;
            r_pos     <= 6'd0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_pos <= 6'd0;
        end else begin
            r_ok  <= 1'b0;
            r_err <= 1'b0;
            if (in_valid) begin
                if (r_state == FLUSH) begin
                    if (in_last) begin
                        r_state <= IDLE;
                        r_exp   <= 4'd0;
                        r_pos   <= 6'd0;
                    end
                end else if (w_match) begin
                    r_state <= state_t'(w_nstate);
                    r_exp   <= w_nexp;
                    if (w_done) begin
                        r_pos <= 6'd0;
                        r_ok  <= 1'b1;
                    end else begin
                        r_pos <= r_pos + 6'd1;
                    end
                end else begin
                    r_err     <= 1'b1;
                    r_err_pos <= r_pos;
                    r_state   <= in_last ? IDLE : FLUSH;
                    r_exp     <= 4'd0;
                    r_pos     <= 6'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fcnt <= '0;
            r_ecnt <= '0;
        end else if (cnt_clr) begin
            r_fcnt <= '0;
            r_ecnt <= '0;
        end else begin
            if (r_ok && (r_fcnt != '1))
                r_fcnt <= r_fcnt + CNT_W'(1);
            if (r_err && (r_ecnt != '1))
                r_ecnt <= r_ecnt + CNT_W'(1);
        end
    end

    assign busy      = (r_state != IDLE);
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    assign err_pos   = r_err_pos;
    assign frame_cnt = r_fcnt;
    assign err_cnt   = r_ecnt;

endmodule

// File: tb/tb_seq_chk.sv
// Scoreboard bench for seq_chk with a frame-level reference model.
// Two instances (CNT_W=8 and CNT_W=2) share the same stimulus.
module tb_seq_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_last = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       busy1, ok1, err1;
    logic [5:0] ep1;
    logic [7:0] fc1, ec1;
    logic       busy2, ok2, err2;
    logic [5:0] ep2;
    logic [1:0] fc2, ec2;

    seq_chk #(.CNT_W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .cnt_clr   (cnt_clr),
        .busy      (busy1),
        .frame_ok  (ok1),
        .frame_err (err1),
        .err_pos   (ep1),
        .frame_cnt (fc1),
        .err_cnt   (ec1)
    );

    seq_chk #(.CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .cnt_clr   (cnt_clr),
        .busy      (busy2),
        .frame_ok  (ok2),
        .frame_err (err2),
        .err_pos   (ep2),
        .frame_cnt (fc2),
        .err_cnt   (ec2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ok;
        logic [5:0] pos;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   ref_sym[40];
    int   mpos, mflush;
    logic mbusy_pend, mbusy_q;
    logic pok, perr;
    int   mep, mfc8, mec8, mfc2, mec2;
    int   n_chk, n_fail;

    function automatic void chk(input string nm, input int act,
                                input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, expv, $time);
        end
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    // Frame-level model: position in the reference table plus a flush flag
    function automatic void model_accept(input int d, input bit l);
        exp_t e;
        if (mflush != 0) begin
            if (l) begin
                mflush = 0;
                mpos   = 0;
            end
        end else if (d == ref_sym[mpos] && l == (mpos == 39)) begin
            if (mpos == 39) begin
                e.ok  = 1'b1;
                e.pos = 6'd0;
                q.push_back(e);
                mpos = 0;
            end else begin
                mpos++;
            end
        end else begin
            e.ok  = 1'b0;
            e.pos = 6'(mpos);
            q.push_back(e);
            if (l) mpos = 0;
            else   mflush = 1;
        end
        mbusy_pend = (mflush != 0) || (mpos != 0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) mbusy_q <= 1'b0;
        else      mbusy_q <= mbusy_pend;
    end

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mep  = 0;
            mfc8 = 0; mec8 = 0; mfc2 = 0; mec2 = 0;
            chk("reset_out8", int'({busy1, ok1, err1, ep1, fc1, ec1}), 0);
            chk("reset_out2", int'({busy2, ok2, err2, ep2, fc2, ec2}), 0);
        end else begin
            chk("frame_cnt8", int'(fc1), mfc8);
            chk("err_cnt8", int'(ec1), mec8);
            chk("frame_cnt2", int'(fc2), mfc2);
            chk("err_cnt2", int'(ec2), mec2);
            chk("busy8", int'(busy1), int'(mbusy_q));
            chk("busy2", int'(busy2), int'(mbusy_q));
            chk("ok_err_excl", int'(ok1 & err1), 0);
            pok  = 1'b0;
            perr = 1'b0;
            if (ok1 || err1) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    me   = q.pop_front();
                    pok  = me.ok;
                    perr = !me.ok;
                    chk("pulse_kind", int'(ok1), int'(pok));
                    if (perr) mep = int'(me.pos);
                end
            end
            chk("ok2", int'(ok2), int'(pok));
            chk("err2", int'(err2), int'(perr));
            chk("err_pos8", int'(ep1), mep);
            chk("err_pos2", int'(ep2), mep);
            if (cnt_clr) begin
                mfc8 = 0; mec8 = 0; mfc2 = 0; mec2 = 0;
            end else begin
                if (pok) begin
                    mfc8 = sat(mfc8, 255);
                    mfc2 = sat(mfc2, 3);
                end
                if (perr) begin
                    mec8 = sat(mec8, 255);
                    mec2 = sat(mec2, 3);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] d,
                       input logic l, input logic c);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        cnt_clr  = c;
        if (v) model_accept(int'(d), l);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // mode 0 clean, 1 bad data at k, 2 early last at k,
    // 3 no last then junk, 4 abort after k samples
    task automatic send_frame(input int mode, input int k,
                              input int val, input int gmax,
                              input bit rclr);
        logic [3:0] d;
        logic       l;
        for (int i = 0; i < 40; i++) begin
            if (mode == 4 && i == k) return;
            d = 4'(ref_sym[i]);
            l = (i == 39);
            if (mode == 1 && i == k) d = 4'(val);
            if (mode == 2 && i == k) l = 1'b1;
            if (mode == 3) l = 1'b0;
            repeat ($urandom_range(0, gmax))
                cyc(1'b0, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)),
                    rclr && ($urandom_range(0, 15) == 0));
            cyc(1'b1, d, l, 1'b0);
            if (mode == 2 && i == k) return;
        end
        if (mode == 3)
            for (int j = 0; j < 5; j++)
                cyc(1'b1, 4'($urandom_range(0, 15)), j == 4, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        cnt_clr    = 1'b0;
        mpos       = 0;
        mflush     = 0;
        mbusy_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int idx, mode, k, v;
        idx = 0;
        for (int s = 0; s <= 12; s++) ref_sym[idx++] = s;
        for (int s = 11; s >= 0; s--) ref_sym[idx++] = s;
        for (int s = 1; s <= 9; s++)  ref_sym[idx++] = s;
        for (int s = 8; s >= 3; s--)  ref_sym[idx++] = s;
        n_chk      = 0;
        n_fail     = 0;
        mpos       = 0;
        mflush     = 0;
        mbusy_pend = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        send_frame(0, 0, 0, 0, 1'b0);
        idle(3);
        send_frame(0, 0, 0, 5, 1'b0);
        idle(2);
        send_frame(1, 13, 12, 0, 1'b0);
        send_frame(0, 0, 0, 0, 1'b0);
        send_frame(2, 20, 0, 0, 1'b0);
        send_frame(0, 0, 0, 0, 1'b0);
        send_frame(3, 0, 0, 0, 1'b0);
        send_frame(0, 0, 0, 0, 1'b0);
        idle(2);
        send_frame(4, 25, 0, 1, 1'b0);
        do_reset();
        send_frame(0, 0, 0, 0, 1'b0);
        idle(2);

        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd9, 1'b1, 1'b0);
        send_frame(0, 0, 0, 0, 1'b0);

        repeat (16) begin
            mode = $urandom_range(0, 3);
            k    = (mode == 2) ? $urandom_range(0, 38) : $urandom_range(0, 39);
            v    = ref_sym[k] ^ $urandom_range(1, 15);
            send_frame(mode, k, v, 2, 1'b1);
        end

        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (5) send_frame(0, 0, 0, 0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        idle(5);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
